// File: rtl/dwc_pkg.sv
// Shared types and defaults for the dual-core result capture block.
package dwc_pkg;

    localparam int DWC_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2,
        TOUT = 2'd3
    } capture_state_t;

endpackage

// File: rtl/dwc_capture_if.sv
// Core write strobes in, held words and status flags out to the comparator.
interface dwc_capture_if
    import dwc_pkg::*;
#(
    parameter int DATA_W = DWC_DATA_W
);
    logic              wr_a;
    logic [DATA_W-1:0] din_a;
    logic              wr_b;
    logic [DATA_W-1:0] din_b;
    logic              clear;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [1:0]        data_set;
    logic              timeout;
    logic [1:0]        missing;
    logic              overrun;

    modport master (
        output wr_a, din_a, wr_b, din_b, clear,
        input  data_a, data_b, data_set, timeout, missing, overrun
    );

    modport slave (
        input  wr_a, din_a, wr_b, din_b, clear,
        output data_a, data_b, data_set, timeout, missing, overrun
    );

endinterface

// File: rtl/dwc_timer.sv
// Deadline counter: counts while start is high, expire marks the last allowed cycle.
module dwc_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Held at zero whenever not running so a fresh WAIT always begins at 0.
    always_ff @(posedge clk) begin
        if (reset || clear || !start) cnt_q <= '0;
        else                          cnt_q <= cnt_q + CNT_W'(1);
    end

    assign expire = start && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dwc_capture.sv
// Captures one result word from each of two cores, with a deadline between them.
module dwc_capture
    import dwc_pkg::*;
#(
    parameter int DATA_W  = DWC_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    dwc_capture_if.slave  bus
);

    capture_state_t           state_q, state_d;
    logic [1:0]               wr, cap;
    logic [1:0]               set_q, set_d;
    logic [1:0]               miss_q, miss_d;
    logic                     tout_q, tout_d;
    logic                     ovr_q, ovr_d;
    logic                     expire;
    logic [1:0][DATA_W-1:0]   din, data_q;

    assign wr  = {bus.wr_b, bus.wr_a};
    assign din = {bus.din_b, bus.din_a};

    dwc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (state_q == WAIT),
        .clear  (bus.clear),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        tout_d  = tout_q;
        miss_d  = miss_q;
        ovr_d   = ovr_q;
        cap     = '0;
        if (bus.clear) begin
            state_d = IDLE;
            set_d   = '0;
            tout_d  = 1'b0;
            miss_d  = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cap = wr;
                    if (&wr)      state_d = FULL;
                    else if (|wr) state_d = WAIT;
                end
                WAIT: begin
                    // Only the absent side may capture; a late arrival beats expiry.
                    cap = wr & ~set_q;
                    if (|(wr & set_q)) ovr_d = 1'b1;
                    if (|cap) begin
                        state_d = FULL;
                    end else if (expire) begin
                        state_d = TOUT;
                        tout_d  = 1'b1;
                        miss_d  = ~set_q;
                    end
                end
                FULL:    if (|wr) ovr_d = 1'b1;
                TOUT:    if (|wr) ovr_d = 1'b1;
                default: state_d = IDLE;
            endcase
            set_d = set_q | cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            set_q   <= '0;
            tout_q  <= 1'b0;
            miss_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            tout_q  <= tout_d;
            miss_q  <= miss_d;
            ovr_q   <= ovr_d;
        end
    end

    // Words survive clear so software can still inspect them after re-arm.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset)       data_q[i] <= '0;
            else if (cap[i]) data_q[i] <= din[i];
        end
    end

    assign bus.data_a   = data_q[0];
    assign bus.data_b   = data_q[1];
    assign bus.data_set = set_q;
    assign bus.timeout  = tout_q;
    assign bus.missing  = miss_q;
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_dwc_capture.sv
// Directed bench for dwc_capture: a cycle-by-cycle vector table plus timeout sequences.
module tb_dwc_capture;
    import dwc_pkg::*;

    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dwc_capture_if #(.DATA_W(DW)) bus ();

    dwc_capture #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          rst;
        logic          wa;
        logic [DW-1:0] da;
        logic          wb;
        logic [DW-1:0] db;
        logic          clr;
        logic [DW-1:0] eda;
        logic [DW-1:0] edb;
        logic [1:0]    eset;
        logic          eto;
        logic [1:0]    emiss;
        logic          eovr;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    task automatic step(input logic r, input logic wa, input logic [DW-1:0] da,
                        input logic wb, input logic [DW-1:0] db, input logic clr);
        reset     = r;
        bus.wr_a  = wa;
        bus.din_a = da;
        bus.wr_b  = wb;
        bus.din_b = db;
        bus.clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [DW-1:0] eda, input logic [DW-1:0] edb,
                           input logic [1:0] eset, input logic eto, input logic [1:0] emiss,
                           input logic eovr);
        chk({nm, ".data_a"},   bus.data_a,         eda);
        chk({nm, ".data_b"},   bus.data_b,         edb);
        chk({nm, ".data_set"}, DW'(bus.data_set),  DW'(eset));
        chk({nm, ".timeout"},  DW'(bus.timeout),   DW'(eto));
        chk({nm, ".missing"},  DW'(bus.missing),   DW'(emiss));
        chk({nm, ".overrun"},  DW'(bus.overrun),   DW'(eovr));
    endtask

    initial begin
        //           rst  wa  da             wb  db             clr  eda            edb            set    to   miss   ovr
        vt[0]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b00,1'b0,2'b00,1'b0};
        vt[1]  = '{1'b0,1'b1,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'hDEADBEEF, 32'h0,        2'b01,1'b0,2'b00,1'b0};
        vt[2]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 32'h0,        2'b01,1'b0,2'b00,1'b0};
        vt[3]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 32'h0,        2'b01,1'b0,2'b00,1'b0};
        vt[4]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 32'h0,        2'b01,1'b0,2'b00,1'b0};
        vt[5]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 32'h0,        2'b01,1'b0,2'b00,1'b0};
        vt[6]  = '{1'b0,1'b0,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'hDEADBEEF, 32'hDEADBEEF, 2'b11,1'b0,2'b00,1'b0};
        vt[7]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hDEADBEEF, 32'hDEADBEEF, 2'b00,1'b0,2'b00,1'b0};
        vt[8]  = '{1'b0,1'b1,32'h11111111, 1'b1,32'h22222222, 1'b0,32'h11111111, 32'h22222222, 2'b11,1'b0,2'b00,1'b0};
        vt[9]  = '{1'b0,1'b1,32'h33333333, 1'b0,32'h0,        1'b0,32'h11111111, 32'h22222222, 2'b11,1'b0,2'b00,1'b1};
        vt[10] = '{1'b0,1'b0,32'h0,        1'b1,32'h44444444, 1'b1,32'h11111111, 32'h22222222, 2'b00,1'b0,2'b00,1'b0};
        vt[11] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h11111111, 32'h22222222, 2'b00,1'b0,2'b00,1'b0};
        vt[12] = '{1'b0,1'b1,32'h55555555, 1'b0,32'h0,        1'b0,32'h55555555, 32'h22222222, 2'b01,1'b0,2'b00,1'b0};
        vt[13] = '{1'b1,1'b0,32'h0,        1'b1,32'h66666666, 1'b0,32'h0,        32'h0,        2'b00,1'b0,2'b00,1'b0};
        vt[14] = '{1'b0,1'b1,32'h77777777, 1'b0,32'h0,        1'b0,32'h77777777, 32'h0,        2'b01,1'b0,2'b00,1'b0};
        vt[15] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h77777777, 32'h0,        2'b00,1'b0,2'b00,1'b0};

        for (int i = 0; i < NV; i++) begin
            step(vt[i].rst, vt[i].wa, vt[i].da, vt[i].wb, vt[i].db, vt[i].clr);
            chk_all($sformatf("vec%0d", i), vt[i].eda, vt[i].edb, vt[i].eset,
                    vt[i].eto, vt[i].emiss, vt[i].eovr);
        end

        // Only B delivers: timer 0..7, TOUT lands on the 8th cycle after capture.
        step(1'b0, 1'b0, '0, 1'b1, 32'hAAAA0001, 1'b0);
        chk_all("tob_cap", 32'h77777777, 32'hAAAA0001, 2'b10, 1'b0, 2'b00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            idle();
            chk($sformatf("tob_wait%0d.timeout", k), DW'(bus.timeout), DW'(1'b0));
        end
        idle();
        chk_all("tob_expire", 32'h77777777, 32'hAAAA0001, 2'b10, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 32'hBBBB0002, 1'b0, '0, 1'b0);
        chk_all("tob_late_a", 32'h77777777, 32'hAAAA0001, 2'b10, 1'b1, 2'b01, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk_all("tob_clear", 32'h77777777, 32'hAAAA0001, 2'b00, 1'b0, 2'b00, 1'b0);

        // B arrives exactly in the expiry cycle: completion wins over timeout.
        step(1'b0, 1'b1, 32'hCCCC0003, 1'b0, '0, 1'b0);
        chk_all("edge_cap", 32'hCCCC0003, 32'hAAAA0001, 2'b01, 1'b0, 2'b00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            idle();
            chk($sformatf("edge_wait%0d.data_set", k), DW'(bus.data_set), DW'(2'b01));
        end
        step(1'b0, 1'b0, '0, 1'b1, 32'hDDDD0004, 1'b0);
        chk_all("edge_full", 32'hCCCC0003, 32'hDDDD0004, 2'b11, 1'b0, 2'b00, 1'b0);
        idle();
        chk_all("edge_hold", 32'hCCCC0003, 32'hDDDD0004, 2'b11, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // Only A delivers: B reported missing.
        step(1'b0, 1'b1, 32'hEEEE0005, 1'b0, '0, 1'b0);
        for (int k = 1; k <= 8; k++) idle();
        chk_all("toa_expire", 32'hEEEE0005, 32'hDDDD0004, 2'b01, 1'b1, 2'b10, 1'b0);

        // Reset out of TOUT with a strobe present clears everything.
        step(1'b1, 1'b1, 32'hFFFF0006, 1'b1, 32'hFFFF0007, 1'b1);
        chk_all("rst_tout", 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
